mips_cpu_ifetch: RTL and testbench

// - Instruction-fetch bus master: the initiator side of the instruction-memory read interface.
// - Generates word fetch addresses from RESET_VECTOR and issues Avalon-style reads with waitrequest.
// - Buffers {pc, instr} pairs in a small FIFO and hands them to the core with a valid/ready handshake.
// - Discards in-flight data when the core redirects (branch/jump).

---
 rtl/mips_cpu_ifetch_if.sv | 25 ++
 rtl/mips_cpu_ifetch.sv | 154 +++++++++++++++
 tb/tb_mips_cpu_ifetch.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_ifetch_if.sv
// Instruction-fetch bundle: Avalon-style read master toward instruction memory
// plus the valid/ready hand-off and redirect inputs from the core.
interface mips_cpu_ifetch_if;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output avm_address, avm_read, avm_byteenable, instr_valid, instr, instr_pc,
    input  avm_waitrequest, avm_readdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  avm_address, avm_read, avm_byteenable, instr_valid, instr, instr_pc,
    output avm_waitrequest, avm_readdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/mips_cpu_ifetch.sv
// Instruction fetch unit: issues sequential word reads, buffers {pc, instr}
// pairs in a small prefetch FIFO and flushes/refetches on core redirects.
module mips_cpu_ifetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  mips_cpu_ifetch_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      pending_pc_reg, pending_pc_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [31:0]      instr_reg, instr_next;
  logic [31:0]      instr_pc_reg, instr_pc_next;
  logic [31:0]      mem_pc    [FIFO_DEPTH];
  logic [31:0]      mem_instr [FIFO_DEPTH];

  logic        avm_read_c;
  logic        accept, stalled, push, pop;
  logic [31:0] redirect_aligned;
  logic [31:0] pend_sel;

  assign accept           = avm_read_c & ~bus.avm_waitrequest;
  assign stalled          = avm_read_c & bus.avm_waitrequest;
  assign pop              = (count_reg != '0) & bus.instr_ready;
  assign push             = (state_reg == FETCH) & accept & ~bus.redirect;
  assign redirect_aligned = bus.redirect_pc & 32'hFFFF_FFFC;
  // A redirect arriving while discarding replaces the earlier target.
  assign pend_sel         = bus.redirect ? redirect_aligned : pending_pc_reg;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH:   if (bus.redirect && stalled) state_next = DISCARD;
      DISCARD: if (accept) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; the read request never drops mid-stall because count can only fall then
  always_comb begin
    avm_read_c = 1'b0;
    case (state_reg)
      FETCH:   avm_read_c = (count_reg < DEPTH_C);
      DISCARD: avm_read_c = 1'b1;
      default: avm_read_c = 1'b0;
    endcase
  end

  assign bus.avm_read       = avm_read_c;
  assign bus.avm_address    = fetch_pc_reg;
  assign bus.avm_byteenable = 4'hF;
  assign bus.instr_valid    = (count_reg != '0);
  assign bus.instr          = instr_reg;
  assign bus.instr_pc       = instr_pc_reg;

  always_comb begin
    fetch_pc_next   = fetch_pc_reg;
    pending_pc_next = pending_pc_reg;
    case (state_reg)
      IDLE: begin
        if (bus.redirect) fetch_pc_next = redirect_aligned;
      end
      FETCH: begin
        if (bus.redirect) begin
          if (stalled) pending_pc_next = redirect_aligned;
          else         fetch_pc_next   = redirect_aligned;
        end else if (accept) begin
          fetch_pc_next = fetch_pc_reg + 32'd4;
        end
      end
      DISCARD: begin
        pending_pc_next = pend_sel;
        if (accept) fetch_pc_next = pend_sel;
      end
      default: ;
    endcase
  end

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (bus.redirect) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_next = wr_ptr_reg + PTR_W'(push);
      rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    end
  end

  // Head registers follow the FIFO head and hold their value while it is empty.
  always_comb begin
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    if (!bus.redirect && count_next != '0) begin
      if (count_reg - CNT_W'(pop) == '0) begin
        instr_next    = bus.avm_readdata;
        instr_pc_next = fetch_pc_reg;
      end else begin
        instr_next    = mem_instr[rd_ptr_next];
        instr_pc_next = mem_pc[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_reg   <= RESET_VECTOR;
      pending_pc_reg <= RESET_VECTOR;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      instr_reg      <= '0;
      instr_pc_reg   <= '0;
    end else begin
      fetch_pc_reg   <= fetch_pc_next;
      pending_pc_reg <= pending_pc_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      instr_reg      <= instr_next;
      instr_pc_reg   <= instr_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_reg]    <= fetch_pc_reg;
      mem_instr[wr_ptr_reg] <= bus.avm_readdata;
    end
  end
endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// Bench for mips_cpu_ifetch: directed scenarios then random traffic, all
// checked every cycle against a queue-based model of the fetch stream.
module tb_mips_cpu_ifetch;
  localparam logic [31:0] RV    = 32'hBFC00000;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  mips_cpu_ifetch_if bus();

  mips_cpu_ifetch #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of what the core should observe
  logic [31:0] qpc[$];
  logic [31:0] qins[$];
  logic [31:0] next_pc    = RV;
  logic [31:0] pend       = RV;
  logic        disc       = 1'b0;
  logic        idle       = 1'b1;
  logic        exp_read   = 1'b0;
  logic [31:0] last_instr = '0;
  logic [31:0] last_pc    = '0;
  logic        checking   = 1'b0;
  int          accepts    = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic rst_i, input logic wr_i, input logic rdy_i,
                       input logic redir_i, input logic [31:0] rpc_i);
    logic        acc, stall, pop;
    logic [31:0] al;
    reset               = rst_i;
    bus.avm_waitrequest = wr_i;
    bus.instr_ready     = rdy_i;
    bus.redirect        = redir_i;
    bus.redirect_pc     = rpc_i;
    bus.avm_readdata    = wr_i ? $urandom : memfn(bus.avm_address);
    if (checking) begin
      chk("avm_read", 32'(bus.avm_read), 32'(exp_read));
      chk("avm_address", bus.avm_address, next_pc);
      chk("avm_byteenable", 32'(bus.avm_byteenable), 32'h0000_000F);
      chk("instr_valid", 32'(bus.instr_valid), 32'(qpc.size() != 0));
      chk("instr", bus.instr, last_instr);
      chk("instr_pc", bus.instr_pc, last_pc);
    end
    if (rst_i && bus.instr_valid && rdy_i)
      $display("consume pc=%h instr=%h", bus.instr_pc, bus.instr);

    al    = rpc_i & 32'hFFFF_FFFC;
    acc   = exp_read && !wr_i;
    stall = exp_read && wr_i;
    pop   = (qpc.size() != 0) && rdy_i;
    if (!rst_i) begin
      qpc.delete(); qins.delete();
      next_pc = RV; disc = 1'b0; idle = 1'b1;
      last_instr = '0; last_pc = '0;
    end else if (idle) begin
      idle = 1'b0;
      if (redir_i) next_pc = al;
    end else begin
      if (acc) accepts++;
      if (pop) begin void'(qpc.pop_front()); void'(qins.pop_front()); end
      if (disc) begin
        if (redir_i) pend = al;
        if (acc) begin disc = 1'b0; next_pc = pend; end
      end else begin
        if (acc && !redir_i) begin
          qpc.push_back(next_pc);
          qins.push_back(memfn(next_pc));
          next_pc = next_pc + 32'd4;
        end
        if (redir_i) begin
          if (stall) begin disc = 1'b1; pend = al; end
          else next_pc = al;
        end
      end
      if (redir_i) begin qpc.delete(); qins.delete(); end
      if (qpc.size() != 0) begin last_pc = qpc[0]; last_instr = qins[0]; end
    end
    exp_read = !idle && (disc || qpc.size() < DEPTH);
    if (!rst_i) checking = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    reset = 1'b0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = '0;
    bus.instr_ready     = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_pc     = '0;
    @(negedge clk);

    // Streaming: one fetch per cycle
    do_reset();
    repeat (6) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);

    // Core not ready: only DEPTH reads, then drain and resume
    do_reset();
    accepts = 0;
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("reads_while_blocked", 32'(accepts), 32'(DEPTH));
    repeat (5) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);

    // Stall on BFC00004, then redirect while BFC00008 is stalled
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hBFC00101);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
    repeat (4) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);

    // Address wrap at the top of the space
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC);
    repeat (4) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);

    // Reset mid-stall with one entry buffered
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (4) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) != 0,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0,
            $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
